mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single 2r1w simulation RAM port set between instruction fetch (IF) and the
//   load/store unit (D). Uses valid/ready request and response handshakes, fixed D priority
//   with an IF anti-starvation counter, and registered responses (1-cycle latency).
//   Sits between the core pipeline and the RAM wrapper; it is the only driver of the RAM ports.
// PARAMETERS
//   MEM_BASE    64'h8000_0000  physical base of RAM; word index = (addr - MEM_BASE) >> 3
//   STARVE_MAX  4              consecutive D grants while IF waits before IF is forced
//   CNT_W       32             width of optional perf counters
// PORTS
//   clk            in   1   clock, all state on posedge
//   rst_n          in   1   asynchronous active-low reset
//   if_req_valid   in   1   IF fetch request
//   if_req_ready   out  1   IF request accepted this cycle (valid & ready)
//   if_req_addr    in   64  fetch byte address, 4-byte aligned
//   if_rsp_valid   out  1   fetch response valid
//   if_rsp_ready   in   1   IF consumes response
//   if_rsp_data    out  32  instruction word
//   d_req_valid    in   1   D request
//   d_req_ready    out  1   D request accepted this cycle
//   d_req_addr     in   64  byte address (bits [2:0] ignored for indexing)
//   d_req_wen      in   1   1 = store, 0 = load
//   d_req_wdata    in   64  store data
//   d_req_wmask    in   64  store bit mask
//   d_rsp_valid    out  1   D response valid (loads and stores)
//   d_rsp_ready    in   1   D consumes response
//   d_rsp_rdata    out  64  load data; 0 for stores
//   mem_en         out  1   RAM read enable
//   mem_addr       out  64  RAM word index
//   mem_rdata      in   64  RAM combinational read data
//   mem_wen        out  1   RAM write enable (sampled by RAM on posedge)
//   mem_wdata      out  64  RAM write data
//   mem_wmask      out  64  RAM write mask
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; all *_ready, *_rsp_valid, mem_en, mem_wen = 0;
//   rsp data regs = 0; starve_cnt = 0. Pending requests and responses are dropped.
// - FSM: IDLE, RSP_IF, RSP_D. Requests are accepted only when the FSM is IDLE, or when it is
//   in RSP_x and that response handshakes this cycle (back-to-back, one access per cycle).
// - Grant (combinational, in an accept cycle): D if d_req_valid and !(if_req_valid &&
//   starve_cnt==STARVE_MAX); else IF if if_req_valid. Exactly one *_req_ready is high.
// - Grant cycle N: mem_en=1, mem_addr=(addr-MEM_BASE)>>3. For a D store, mem_wen=1 with
//   mem_wdata/mem_wmask. mem_rdata is captured at posedge ending N.
// - Response: rsp_valid=1 from N+1 and held stable until rsp_ready; IF data is
//   addr[2] ? rdata[63:32] : rdata[31:0] (addr[2] is registered at grant).
//   Next state: RSP_IF or RSP_D; it returns to IDLE on handshake with no new grant.
// - starve_cnt: increments (saturating at STARVE_MAX) on each D grant while if_req_valid;
//   cleared on IF grant. When it equals STARVE_MAX, IF wins.
// - Out-of-range addr (< MEM_BASE): no RAM access (mem_en=mem_wen=0); response still
//   issued with data 0.
// - mem_* outputs are 0 in all non-grant cycles, so no spurious writes occur.
// CONFIGURATION
//   MEM_ARB_PERF_EN defined: adds outputs perf_if_grants, perf_d_grants, perf_conflicts
//     (CNT_W each, wrap on overflow, reset 0). A conflict is a cycle with both valid in an
//     accept cycle.
//   MEM_ARB_PERF_EN undefined: these ports and counters do not exist; behaviour is otherwise
//     identical.
// TESTING
//   1. IF only: addr 0x8000_0004, mem word 0xAABBCCDD_11223344 -> if_rsp_data 0xAABBCCDD at N+1.
//   2. Store then load at 0x8000_0010, wdata 0x1234, mask all ones -> load rdata 0x1234, store
//      rsp rdata 0.
//   3. Both valid for 10 cycles, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
//   4. d_rsp_ready=0 for 3 cycles -> d_rsp_valid and data held stable, both req_ready=0.
//   5. rst_n low mid-RSP_D -> rsp_valid=0 immediately; after release, IDLE and starve_cnt=0.
//   6. d_req_addr 0x7FFF_FFF8 store -> mem_wen stays 0; d_rsp_valid=1 with rdata 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one RAM port set between instruction fetch (IF) and the load/store
//   unit (D). D has fixed priority. A starvation counter forces an IF grant
//   after STARVE_MAX consecutive D grants while IF was waiting. At most one
//   access is in flight. Its response is registered and appears one cycle
//   after the grant, then is held until the consumer takes it.
//   Optional feature macro: MEM_ARB_PERF_EN. When it is defined, the module
//   adds the grant and conflict performance counters and their outputs.
module mem_port_arbiter #(
    parameter logic [63:0] MEM_BASE   = 64'h8000_0000,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    // instruction fetch request / response
    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [63:0]      if_req_addr,
    output logic             if_rsp_valid,
    input  logic             if_rsp_ready,
    output logic [31:0]      if_rsp_data,
    // load/store request / response
    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic [63:0]      d_req_addr,
    input  logic             d_req_wen,
    input  logic [63:0]      d_req_wdata,
    input  logic [63:0]      d_req_wmask,
    output logic             d_rsp_valid,
    input  logic             d_rsp_ready,
    output logic [63:0]      d_rsp_rdata,
    // RAM port set
    output logic             mem_en,
    output logic [63:0]      mem_addr,
    input  logic [63:0]      mem_rdata,
    output logic             mem_wen,
    output logic [63:0]      mem_wdata,
    output logic [63:0]      mem_wmask
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_if_grants,
    output logic [CNT_W-1:0] perf_d_grants,
    output logic [CNT_W-1:0] perf_conflicts
`endif
);

    localparam int unsigned STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_IF = 2'd1,
        RSP_D  = 2'd2
    } state_t;

    state_t             state_q;
    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;
    logic               if_rsp_valid_q;
    logic [31:0]        if_rsp_data_q;
    logic [31:0]        if_rsp_data_d;
    logic               d_rsp_valid_q;
    logic [63:0]        d_rsp_rdata_q;
    logic [63:0]        d_rsp_rdata_d;

    logic               accept;
    logic               if_forced;
    logic               grant_d;
    logic               grant_if;
    logic               if_in_range;
    logic               d_in_range;
    logic [63:0]        if_offset;
    logic [63:0]        d_offset;

    // Address decode: anything below MEM_BASE is out of range and never touches RAM.
    always_comb begin
        if_in_range = (if_req_addr >= MEM_BASE);
        d_in_range  = (d_req_addr >= MEM_BASE);
        if_offset   = if_req_addr - MEM_BASE;
        d_offset    = d_req_addr - MEM_BASE;
    end

    // Accept cycle: idle, or the outstanding response handshakes now.
    // The rst_n term keeps every ready low while reset is asserted.
    always_comb begin
        accept = 1'b0;
        case (state_q)
            IDLE:    accept = 1'b1;
            RSP_IF:  accept = if_rsp_ready;
            RSP_D:   accept = d_rsp_ready;
            default: accept = 1'b0;
        endcase
        accept = accept & rst_n;
    end

    // Grant: D wins unless IF has waited out STARVE_MAX D grants.
    always_comb begin
        if_forced = if_req_valid && (starve_cnt_q == STARVE_LIM);
        grant_d   = accept && d_req_valid && !if_forced;
        grant_if  = accept && if_req_valid && !grant_d;
    end

    assign d_req_ready  = grant_d;
    assign if_req_ready = grant_if;

    // RAM drive: active only in a grant cycle for an in-range address.
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = 64'd0;
        mem_wen   = 1'b0;
        mem_wdata = 64'd0;
        mem_wmask = 64'd0;
        if (grant_d && d_in_range) begin
            mem_en   = 1'b1;
            mem_addr = d_offset >> 3;
            if (d_req_wen) begin
                mem_wen   = 1'b1;
                mem_wdata = d_req_wdata;
                mem_wmask = d_req_wmask;
            end
        end else if (grant_if && if_in_range) begin
            mem_en   = 1'b1;
            mem_addr = if_offset >> 3;
        end
    end

    // Response data: the RAM reads combinationally, so the grant-cycle read
    // data is selected here and captured at the clock edge that ends the grant.
    // Address bit 2 picks the upper or lower instruction word of the 64-bit RAM word.
    always_comb begin
        if_rsp_data_d = 32'd0;
        d_rsp_rdata_d = 64'd0;
        if (if_in_range) begin
            if_rsp_data_d = if_req_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        end
        if (d_in_range && !d_req_wen) begin
            d_rsp_rdata_d = mem_rdata;
        end
    end

    // Starvation counter next value: saturating count of D grants that made a waiting IF lose.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_d && if_req_valid && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Main FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            starve_cnt_q   <= '0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= 32'd0;
            d_rsp_valid_q  <= 1'b0;
            d_rsp_rdata_q  <= 64'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                RSP_IF: begin
                    if (if_rsp_ready) begin
                        if_rsp_valid_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                RSP_D: begin
                    if (d_rsp_ready) begin
                        d_rsp_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // A new grant overrides the return to idle (back-to-back accesses).
            if (grant_d) begin
                state_q       <= RSP_D;
                d_rsp_valid_q <= 1'b1;
                d_rsp_rdata_q <= d_rsp_rdata_d;
            end else if (grant_if) begin
                state_q        <= RSP_IF;
                if_rsp_valid_q <= 1'b1;
                if_rsp_data_q  <= if_rsp_data_d;
            end
        end
    end

    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign d_rsp_valid  = d_rsp_valid_q;
    assign d_rsp_rdata  = d_rsp_rdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [CNT_W-1:0] perf_if_grants_q;
    logic [CNT_W-1:0] perf_d_grants_q;
    logic [CNT_W-1:0] perf_conflicts_q;

    // Performance counters: grants per requester and contended accept cycles; all wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_grants_q <= '0;
            perf_d_grants_q  <= '0;
            perf_conflicts_q <= '0;
        end else begin
            if (grant_if) begin
                perf_if_grants_q <= perf_if_grants_q + 1'b1;
            end
            if (grant_d) begin
                perf_d_grants_q <= perf_d_grants_q + 1'b1;
            end
            if (accept && if_req_valid && d_req_valid) begin
                perf_conflicts_q <= perf_conflicts_q + 1'b1;
            end
        end
    end

    assign perf_if_grants = perf_if_grants_q;
    assign perf_d_grants  = perf_d_grants_q;
    assign perf_conflicts = perf_conflicts_q;
`endif

endmodule
